// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM status and the memory arbiter FSM encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-to-memory bus: per-CPU icache/dcache request lines plus the single RAM port.
interface mem_arbiter_if #(
  parameter int CPUS = 2
);
  import cpu_types_pkg::*;

  // icache side
  logic [CPUS-1:0] iREN;
  word_t [CPUS-1:0] iaddr;
  logic [CPUS-1:0] iwait;
  word_t [CPUS-1:0] iload;

  // dcache side
  logic [CPUS-1:0] dREN;
  logic [CPUS-1:0] dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0] dwait;
  word_t [CPUS-1:0] dload;

  // RAM side
  logic ramREN;
  logic ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  ramstate_t ramstate;

  // Arbiter (memory controller) view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Caches plus RAM model view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping around.
// Returns a one-hot grant and its index; any is low when nothing requests.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IDX_W = $clog2(N);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [IDX_W-1:0] off_s;
  logic [IDX_W:0] sum_s;

  // Rotate requests so bit 0 is the pointer slot, then take the lowest set bit.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[N-1:0];
    off_s = '0;
    any   = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        off_s = IDX_W'(j);
        any   = 1'b1;
      end else begin
      end
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= (IDX_W + 1)'(N)) begin
      idx = IDX_W'(sum_s - (IDX_W + 1)'(N));
    end else begin
      idx = sum_s[IDX_W-1:0];
    end
    if (any) begin
      grant = ONE_HOT0 << idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory controller: serialises icache fills and dcache reads/writes from all CPUs
// onto one RAM port with round-robin fairness over slots d0, i0, d1, i1, ...
module mem_arbiter #(
  parameter int CPUS = 2
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave cif
);
  import cpu_types_pkg::*;

  localparam int SLOTS = 2 * CPUS;
  localparam int PTR_W = $clog2(SLOTS);

  arb_state_t       state_r;
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] slot_r;
  logic             write_r;

  logic [SLOTS-1:0] req_s;
  logic [SLOTS-1:0] wr_s;
  logic [SLOTS-1:0] grant_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic             any_s;
  logic             pick_write_s;
  logic             slot_req_s;
  logic             complete_s;

  // Map per-CPU request lines onto slot order: even slots dcache, odd slots icache.
  always_comb begin
    req_s = '0;
    wr_s  = '0;
    for (int c = 0; c < CPUS; c++) begin
      req_s[2*c]   = cif.dREN[c] | cif.dWEN[c];
      req_s[2*c+1] = cif.iREN[c];
      wr_s[2*c]    = cif.dWEN[c];
    end
  end

  rr_picker #(
    .N(SLOTS)
  ) u_picker (
    .req  (req_s),
    .ptr  (ptr_r),
    .grant(grant_s),
    .idx  (pick_idx_s),
    .any  (any_s)
  );

  // A dcache raising both REN and WEN is served as a write.
  assign pick_write_s = |(grant_s & wr_s);
  assign slot_req_s   = req_s[slot_r];
  assign complete_s   = (state_r == GRANT) && slot_req_s && (cif.ramstate == ACCESS);
  assign next_ptr_s   = (slot_r == PTR_W'(SLOTS - 1)) ? '0 : slot_r + PTR_W'(1);

  // Grant FSM: latch a slot in IDLE, release on completion (advance pointer) or abort.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      slot_r  <= '0;
      write_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            state_r <= GRANT;
            slot_r  <= pick_idx_s;
            write_r <= pick_write_s;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (!slot_req_s) begin
            // Requester withdrew before ACCESS: drop the grant, keep the pointer.
            state_r <= IDLE;
          end else if (complete_s) begin
            state_r <= IDLE;
            ptr_r   <= next_ptr_s;
          end else begin
            // BUSY, FREE and ERROR all mean hold and retry.
            state_r <= GRANT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // RAM strobes follow the registered grant; address/data come from the owner's live inputs.
  always_comb begin
    cif.ramREN   = 1'b0;
    cif.ramWEN   = 1'b0;
    cif.ramaddr  = '0;
    cif.ramstore = '0;
    if (state_r == GRANT) begin
      cif.ramREN = ~write_r;
      cif.ramWEN = write_r;
      for (int c = 0; c < CPUS; c++) begin
        if (slot_r == PTR_W'(2 * c)) begin
          cif.ramaddr  = cif.daddr[c];
          cif.ramstore = cif.dstore[c];
        end else if (slot_r == PTR_W'(2 * c + 1)) begin
          cif.ramaddr = cif.iaddr[c];
        end else begin
        end
      end
    end else begin
      cif.ramREN = 1'b0;
    end
  end

  // Broadcast load data; only the owning slot's wait drops, and only in its ACCESS cycle.
  always_comb begin
    cif.iwait = '1;
    cif.dwait = '1;
    cif.iload = '0;
    cif.dload = '0;
    for (int c = 0; c < CPUS; c++) begin
      cif.iload[c] = cif.ramload;
      cif.dload[c] = cif.ramload;
      if (complete_s && (slot_r == PTR_W'(2 * c))) begin
        cif.dwait[c] = 1'b0;
      end else if (complete_s && (slot_r == PTR_W'(2 * c + 1))) begin
        cif.iwait[c] = 1'b0;
      end else begin
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (CPUS=2): the stimulus pushes expected completions
// (slot, load data) into a queue; a negedge monitor pops and checks every wait-low pulse.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct {
    int          slot;
    logic [31:0] data;
  } exp_t;

  logic CLK;
  logic nRST;
  int   compared;
  int   mismatched;
  exp_t exp_q[$];

  mem_arbiter_if #(.CPUS(2)) cif ();

  mem_arbiter #(.CPUS(2)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .cif (cif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_done(input int slot, input logic [31:0] data);
    exp_t e;
    e.slot = slot;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_reqs();
    cif.iREN = 2'b00;
    cif.dREN = 2'b00;
    cif.dWEN = 2'b00;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    clear_reqs();
    cif.ramstate = FREE;
    @(posedge CLK);
    #3;
    nRST = 1'b1;
  endtask

  // Monitor: every wait-low pulse must match the head of the expectation queue.
  initial begin
    int   lows;
    exp_t e;
    forever begin
      @(negedge CLK);
      lows = 0;
      for (int s = 0; s < 4; s++) begin
        logic  w;
        word_t ld;
        w  = (s % 2 == 1) ? cif.iwait[s/2] : cif.dwait[s/2];
        ld = (s % 2 == 1) ? cif.iload[s/2] : cif.dload[s/2];
        if (!w) begin
          lows++;
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL mon_unexpected: slot %0d completed, expected no completion", s);
          end else begin
            e = exp_q.pop_front();
            if (e.slot != s || e.data !== ld) begin
              mismatched++;
              $display("FAIL mon_completion: got slot %0d data %h expected slot %0d data %h",
                       s, ld, e.slot, e.data);
            end
          end
        end
      end
      if (lows > 1) begin
        compared++;
        mismatched++;
        $display("FAIL mon_one_wait: got %0d waits low expected at most 1", lows);
      end
    end
  end

  // Directed stimulus.
  initial begin
    compared   = 0;
    mismatched = 0;
    nRST       = 1'b0;
    clear_reqs();
    cif.iaddr    = '0;
    cif.daddr    = '0;
    cif.dstore   = '0;
    cif.ramload  = '0;
    cif.ramstate = FREE;

    // Reset values
    #7;
    chk("rst_waits", {cif.iwait, cif.dwait}, 32'hF);
    chk("rst_ren", cif.ramREN, 32'd0);
    chk("rst_wen", cif.ramWEN, 32'd0);
    chk("rst_addr", cif.ramaddr, 32'd0);
    chk("rst_store", cif.ramstore, 32'd0);
    #1;
    nRST = 1'b1;

    // Single read on i0, two BUSY cycles then ACCESS
    next_cycle();
    cif.iREN[0] = 1'b1;
    cif.iaddr[0] = 32'h0000_0100;
    expect_done(1, 32'hDEAD_BEEF);
    #2;
    chk("rd_idle_ren", cif.ramREN, 32'd0);
    next_cycle();
    cif.ramstate = BUSY;
    #2;
    chk("rd_ren", cif.ramREN, 32'd1);
    chk("rd_addr", cif.ramaddr, 32'h0000_0100);
    chk("rd_busy_waits", {cif.iwait, cif.dwait}, 32'hF);
    next_cycle();
    #2;
    chk("rd_ren_hold", cif.ramREN, 32'd1);
    next_cycle();
    cif.ramstate = ACCESS;
    cif.ramload = 32'hDEAD_BEEF;
    #2;
    chk("rd_iwait", cif.iwait, 32'd2);
    next_cycle();
    cif.iREN[0] = 1'b0;
    cif.ramstate = FREE;
    #2;
    chk("rd_after_ren", cif.ramREN, 32'd0);
    chk("rd_after_waits", {cif.iwait, cif.dwait}, 32'hF);

    // Write on d1
    next_cycle();
    cif.dWEN[1] = 1'b1;
    cif.daddr[1] = 32'h0000_0200;
    cif.dstore[1] = 32'h1234_5678;
    expect_done(2, 32'hCAFE_0002);
    next_cycle();
    cif.ramstate = BUSY;
    #2;
    chk("wr_wen", cif.ramWEN, 32'd1);
    chk("wr_ren", cif.ramREN, 32'd0);
    chk("wr_addr", cif.ramaddr, 32'h0000_0200);
    chk("wr_store", cif.ramstore, 32'h1234_5678);
    next_cycle();
    cif.ramstate = ACCESS;
    cif.ramload = 32'hCAFE_0002;
    #2;
    chk("wr_dwait", cif.dwait, 32'd1);
    next_cycle();
    cif.dWEN[1] = 1'b0;
    cif.ramstate = FREE;
    #2;
    chk("wr_dwait_after", cif.dwait, 32'd3);
    chk("wr_wen_after", cif.ramWEN, 32'd0);

    // Fairness from reset: all slots request, RAM answers at once
    do_reset();
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (k == 0) begin
        cif.dREN = 2'b11;
        cif.iREN = 2'b11;
        cif.daddr[0] = 32'h0000_1000;
        cif.iaddr[0] = 32'h0000_1004;
        cif.daddr[1] = 32'h0000_1008;
        cif.iaddr[1] = 32'h0000_100C;
        expect_done(0, 32'hF000_0001);
        expect_done(1, 32'hF000_0003);
        expect_done(2, 32'hF000_0005);
        expect_done(3, 32'hF000_0007);
        expect_done(0, 32'hF000_0009);
      end
      cif.ramstate = ACCESS;
      cif.ramload = 32'hF000_0000 + 32'(k);
      #2;
      chk("fair_strobe", cif.ramREN, 32'(k % 2));
    end
    next_cycle();
    clear_reqs();
    cif.ramstate = FREE;
    #2;
    chk("fair_end_ren", cif.ramREN, 32'd0);

    // Abort: grant i1, withdraw while BUSY; pointer stays at 1 so i0 wins next
    next_cycle();
    cif.iREN[1] = 1'b1;
    cif.iaddr[1] = 32'h0000_0300;
    cif.ramstate = BUSY;
    next_cycle();
    #2;
    chk("abort_ren", cif.ramREN, 32'd1);
    chk("abort_addr", cif.ramaddr, 32'h0000_0300);
    next_cycle();
    cif.iREN[1] = 1'b0;
    #2;
    chk("abort_waits", {cif.iwait, cif.dwait}, 32'hF);
    next_cycle();
    cif.dREN = 2'b11;
    cif.iREN = 2'b11;
    cif.iaddr[0] = 32'h0000_0400;
    expect_done(1, 32'hAB0A_0001);
    #2;
    chk("abort_ren_fall", cif.ramREN, 32'd0);
    next_cycle();
    cif.ramstate = ACCESS;
    cif.ramload = 32'hAB0A_0001;
    #2;
    chk("abort_next_addr", cif.ramaddr, 32'h0000_0400);
    next_cycle();
    clear_reqs();
    cif.ramstate = FREE;
    #2;
    chk("abort_end_ren", cif.ramREN, 32'd0);

    // ERROR held three cycles on d0 with REN and WEN both high (served as write)
    next_cycle();
    cif.dREN[0] = 1'b1;
    cif.dWEN[0] = 1'b1;
    cif.daddr[0] = 32'h0000_0500;
    cif.dstore[0] = 32'h55AA_55AA;
    expect_done(0, 32'h0E0E_0E0E);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      cif.ramstate = ERROR;
      #2;
      chk("err_waits", {cif.iwait, cif.dwait}, 32'hF);
      chk("err_wen", cif.ramWEN, 32'd1);
      chk("err_ren", cif.ramREN, 32'd0);
    end
    chk("err_store", cif.ramstore, 32'h55AA_55AA);
    next_cycle();
    cif.ramstate = ACCESS;
    cif.ramload = 32'h0E0E_0E0E;
    #2;
    chk("err_dwait", cif.dwait, 32'd2);
    next_cycle();
    clear_reqs();
    cif.ramstate = FREE;
    #2;
    chk("err_end_waits", {cif.iwait, cif.dwait}, 32'hF);

    // Reset mid-grant: d1 holds the RAM, reset drops it, d0 wins afterwards
    next_cycle();
    cif.dREN = 2'b11;
    cif.daddr[0] = 32'h0000_0700;
    cif.daddr[1] = 32'h0000_0600;
    cif.ramstate = BUSY;
    next_cycle();
    #1;
    chk("mid_ren", cif.ramREN, 32'd1);
    chk("mid_addr", cif.ramaddr, 32'h0000_0600);
    nRST = 1'b0;
    #1;
    chk("mid_rst_ren", cif.ramREN, 32'd0);
    chk("mid_rst_wen", cif.ramWEN, 32'd0);
    chk("mid_rst_addr", cif.ramaddr, 32'd0);
    chk("mid_rst_waits", {cif.iwait, cif.dwait}, 32'hF);
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    cif.ramstate = FREE;
    expect_done(0, 32'h7777_0000);
    next_cycle();
    cif.ramstate = ACCESS;
    cif.ramload = 32'h7777_0000;
    #2;
    chk("post_rst_addr", cif.ramaddr, 32'h0000_0700);
    chk("post_rst_ren", cif.ramREN, 32'd1);
    next_cycle();
    clear_reqs();
    cif.ramstate = FREE;

    next_cycle();
    next_cycle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
